// File: rtl/cnn_axil_slave_regs.sv
// ---------------------------------------------------------------------------
// cnn_axil_slave_regs
//
// AXI4-Lite slave register bank for the CNN accelerator control plane.
// Single-beat reads and writes are decoded into a control register, a
// status register and a set of generic configuration registers that are
// exported straight to the datapath. A level interrupt is raised when the
// accelerator reports completion and interrupts are enabled.
//
// Register map (word index = address[ADDR_W-1:2], address[1:0] ignored):
//   0        CTRL    bit0 start (write 1 pulses start_o, reads 0)
//                    bit1 irq_en (read/write)
//   1        STATUS  bit0 busy (live copy of busy_i)
//                    bit1 done (sticky, set by done_i, write-1-to-clear)
//   2..N-1   CFG     plain read/write, driven onto cfg_o
//   >= N             SLVERR, writes dropped, reads return 0
//
// Ports:
//   aclk, aresetn        clock (rising edge) and async active-low reset
//   s_axi_aw*            write address channel
//   s_axi_w*             write data channel
//   s_axi_b*             write response channel
//   s_axi_ar*            read address channel
//   s_axi_r*             read data channel
//   busy_i, done_i       accelerator busy level and done pulse
//   start_o              one-cycle start pulse
//   irq_o                level interrupt = irq_en & done
//   cfg_o                CFG registers, register 2 in bits [31:0]
//
// Build option:
//   CNN_AXIL_WSTRB_EN    when defined, byte strobes select which lanes are
//                        written; CTRL/STATUS bit actions need lane 0.
//                        When undefined, every write is a full word.
// ---------------------------------------------------------------------------
module cnn_axil_slave_regs #(
    parameter int ADDR_W   = 12,
    parameter int NUM_REGS = 8
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [ADDR_W-1:0]          s_axi_awaddr,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [31:0]                s_axi_wdata,
    input  logic [3:0]                 s_axi_wstrb,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    input  logic [ADDR_W-1:0]          s_axi_araddr,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [31:0]                s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    input  logic                       busy_i,
    input  logic                       done_i,
    output logic                       start_o,
    output logic                       irq_o,
    output logic [32*(NUM_REGS-2)-1:0] cfg_o
);

    localparam int               IDX_W     = ADDR_W - 2;
    localparam int               NUM_CFG   = NUM_REGS - 2;
    localparam logic [IDX_W:0]   REG_LIMIT = NUM_REGS[IDX_W:0];
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    // Goes high on the first edge after reset release; gates all readies
    // so nothing is accepted while reset is asserted.
    logic              r_live;

    // Write-side holding registers and response state
    logic              r_aw_held;
    logic [IDX_W-1:0]  r_aw_idx;
    logic              r_w_held;
    logic [31:0]       r_w_data;
    logic [3:0]        r_w_strb;
    logic              r_bvalid;
    logic [1:0]        r_bresp;

    // Read-side holding register and response state
    logic              r_ar_held;
    logic [IDX_W-1:0]  r_ar_idx;
    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;

    // Architectural register contents
    logic              r_irq_en;
    logic              r_done;
    logic              r_start;
    logic [31:0]       r_cfg [NUM_CFG];

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_ar_hs;
    logic              w_commit;
    logic              w_aw_in_range;
    logic              w_ar_in_range;
    logic [3:0]        w_strb_in;
    logic [31:0]       w_wmask;
    logic              w_ctrl_wr;
    logic              w_stat_wr;
    logic [31:0]       w_rd_data;
    logic              w_unused_bits;

`ifdef CNN_AXIL_WSTRB_EN
    assign w_strb_in     = s_axi_wstrb;
    assign w_unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`else
    // Strobes are ignored: every write behaves as a full-word write.
    assign w_strb_in     = 4'hF;
    assign w_unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb};
`endif

    // Readies depend only on registered state, so they never combinationally
    // follow a valid and the master sees a clean handshake.
    assign s_axi_awready = r_live & ~r_aw_held & ~r_bvalid;
    assign s_axi_wready  = r_live & ~r_w_held  & ~r_bvalid;
    assign s_axi_arready = r_live & ~r_ar_held & ~r_rvalid;

    assign w_aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_w_hs  = s_axi_wvalid  & s_axi_wready;
    assign w_ar_hs = s_axi_arvalid & s_axi_arready;

    // A write commits on the edge after both address and data are held.
    assign w_commit      = r_aw_held & r_w_held;
    assign w_aw_in_range = ({1'b0, r_aw_idx} < REG_LIMIT);
    assign w_ar_in_range = ({1'b0, r_ar_idx} < REG_LIMIT);

    // CTRL and STATUS bit actions live in byte lane 0.
    assign w_ctrl_wr = w_commit & (r_aw_idx == '0)        & r_w_strb[0];
    assign w_stat_wr = w_commit & (r_aw_idx == IDX_W'(1)) & r_w_strb[0];

    // Expand the captured strobes into a bit mask for read-modify-write.
    always_comb begin
        w_wmask = '0;
        for (int b = 0; b < 4; b++) begin
            if (r_w_strb[b]) begin
                w_wmask[8*b +: 8] = 8'hFF;
            end
        end
    end

    // Write address/data capture and write response generation.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_live    <= 1'b0;
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_live <= 1'b1;

            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s_axi_awaddr[ADDR_W-1:2];
            end else if (w_commit) begin
                r_aw_held <= 1'b0;
            end

            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_w_data <= s_axi_wdata;
                r_w_strb <= w_strb_in;
            end else if (w_commit) begin
                r_w_held <= 1'b0;
            end

            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Register file updates. An out-of-range index matches no register, so
    // such writes fall through without touching state. A done pulse arriving
    // on the same edge as a clear wins so a completion is never lost.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_start  <= 1'b0;
            for (int i = 0; i < NUM_CFG; i++) begin
                r_cfg[i] <= '0;
            end
        end else begin
            r_start <= w_ctrl_wr & r_w_data[0];

            if (w_ctrl_wr) begin
                r_irq_en <= r_w_data[1];
            end

            r_done <= done_i | (r_done & ~(w_stat_wr & r_w_data[1]));

            for (int i = 0; i < NUM_CFG; i++) begin
                if (w_commit && (r_aw_idx == IDX_W'(i + 2))) begin
                    r_cfg[i] <= (r_cfg[i] & ~w_wmask) | (r_w_data & w_wmask);
                end
            end
        end
    end

    // Read data selection from the held read index; unmapped indices read 0.
    always_comb begin
        w_rd_data = '0;
        if (r_ar_idx == '0) begin
            w_rd_data = {30'b0, r_irq_en, 1'b0};
        end else if (r_ar_idx == IDX_W'(1)) begin
            w_rd_data = {30'b0, r_done, busy_i};
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (r_ar_idx == IDX_W'(i + 2)) begin
                    w_rd_data = r_cfg[i];
                end
            end
        end
    end

    // Read address capture and read response. Data is sampled on the same
    // edge a write may commit, so a coincident read sees the old value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ar_held <= 1'b0;
            r_ar_idx  <= '0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            if (w_ar_hs) begin
                r_ar_held <= 1'b1;
                r_ar_idx  <= s_axi_araddr[ADDR_W-1:2];
            end else if (r_ar_held) begin
                r_ar_held <= 1'b0;
            end

            if (r_ar_held) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (r_rvalid && s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Flatten the CFG registers onto the output bus, register 2 lowest.
    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
        assign cfg_o[32*g +: 32] = r_cfg[g];
    end

    assign s_axi_bvalid = r_bvalid;
    assign s_axi_bresp  = r_bresp;
    assign s_axi_rvalid = r_rvalid;
    assign s_axi_rdata  = r_rdata;
    assign s_axi_rresp  = r_rresp;
    assign start_o      = r_start;
    assign irq_o        = r_irq_en & r_done;

endmodule

// File: tb/tb_cnn_axil_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_cnn_axil_slave_regs
//
// Directed bench for the AXI4-Lite register bank. A transaction-level model
// tracks register contents and channel occupancy; a compare process checks
// every DUT output against it on each falling edge, and the directed
// sequence adds hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_cnn_axil_slave_regs;

    localparam int ADDR_W   = 12;
    localparam int NUM_REGS = 8;
    localparam int NUM_CFG  = NUM_REGS - 2;

    logic                   aclk = 1'b0;
    logic                   aresetn = 1'b1;
    logic [ADDR_W-1:0]      s_axi_awaddr = '0;
    logic                   s_axi_awvalid = 1'b0;
    logic                   s_axi_awready;
    logic [31:0]            s_axi_wdata = '0;
    logic [3:0]             s_axi_wstrb = '0;
    logic                   s_axi_wvalid = 1'b0;
    logic                   s_axi_wready;
    logic [1:0]             s_axi_bresp;
    logic                   s_axi_bvalid;
    logic                   s_axi_bready = 1'b0;
    logic [ADDR_W-1:0]      s_axi_araddr = '0;
    logic                   s_axi_arvalid = 1'b0;
    logic                   s_axi_arready;
    logic [31:0]            s_axi_rdata;
    logic [1:0]             s_axi_rresp;
    logic                   s_axi_rvalid;
    logic                   s_axi_rready = 1'b0;
    logic                   busy_i = 1'b0;
    logic                   done_i = 1'b0;
    logic                   start_o;
    logic                   irq_o;
    logic [32*NUM_CFG-1:0]  cfg_o;

    int errors = 0;
    int checks = 0;
    int startCount = 0;
    bit compareOn = 1'b0;

    cnn_axil_slave_regs #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .busy_i(busy_i), .done_i(done_i), .start_o(start_o), .irq_o(irq_o), .cfg_o(cfg_o)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          mLive = 0;
    bit          mAwPend = 0;
    int          mAwIdx = 0;
    bit          mWPend = 0;
    logic [31:0] mWData = '0;
    logic [3:0]  mWStrb = '0;
    bit          mB = 0;
    logic [1:0]  mBresp = '0;
    bit          mArPend = 0;
    int          mArIdx = 0;
    bit          mR = 0;
    logic [31:0] mRdata = '0;
    logic [1:0]  mRresp = '0;
    bit          mIrqEn = 0;
    bit          mDone = 0;
    bit          mStart = 0;
    logic [31:0] mCfg [NUM_CFG];

    function automatic logic [31:0] modelRead(input int idx);
        if (idx >= NUM_REGS) return 32'h0;
        if (idx == 0) return mIrqEn ? 32'h2 : 32'h0;
        if (idx == 1) return (mDone ? 32'h2 : 32'h0) + (busy_i ? 32'h1 : 32'h0);
        return mCfg[idx-2];
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mLive = 0; mAwPend = 0; mWPend = 0; mB = 0; mArPend = 0; mR = 0;
            mIrqEn = 0; mDone = 0; mStart = 0;
            mBresp = '0; mRdata = '0; mRresp = '0;
            for (int i = 0; i < NUM_CFG; i++) mCfg[i] = '0;
        end else begin
            bit awRdy, wRdy, arRdy, clearDone;
            logic [3:0]  st;
            logic [31:0] mk;
            awRdy = mLive && !mAwPend && !mB;
            wRdy  = mLive && !mWPend  && !mB;
            arRdy = mLive && !mArPend && !mR;
            clearDone = 0;
            mStart = 0;

            if (mR && s_axi_rready) mR = 0;
            if (mArPend) begin
                mRdata  = modelRead(mArIdx);
                mRresp  = (mArIdx < NUM_REGS) ? 2'b00 : 2'b10;
                mR      = 1;
                mArPend = 0;
            end
            if (s_axi_arvalid && arRdy) begin
                mArPend = 1;
                mArIdx  = int'(s_axi_araddr) / 4;
            end

            if (mB && s_axi_bready) mB = 0;
            if (mAwPend && mWPend) begin
`ifdef CNN_AXIL_WSTRB_EN
                st = mWStrb;
`else
                st = 4'hF;
`endif
                mk = '0;
                for (int b = 0; b < 4; b++) if (st[b]) mk[8*b +: 8] = 8'hFF;
                if (mAwIdx >= NUM_REGS) begin
                    mBresp = 2'b10;
                end else begin
                    mBresp = 2'b00;
                    if (mAwIdx == 0 && st[0]) begin
                        mIrqEn = mWData[1];
                        mStart = mWData[0];
                    end else if (mAwIdx == 1 && st[0] && mWData[1]) begin
                        clearDone = 1;
                    end else if (mAwIdx >= 2) begin
                        mCfg[mAwIdx-2] = (mCfg[mAwIdx-2] & ~mk) | (mWData & mk);
                    end
                end
                mB = 1; mAwPend = 0; mWPend = 0;
            end
            if (s_axi_awvalid && awRdy) begin
                mAwPend = 1;
                mAwIdx  = int'(s_axi_awaddr) / 4;
            end
            if (s_axi_wvalid && wRdy) begin
                mWPend = 1;
                mWData = s_axi_wdata;
                mWStrb = s_axi_wstrb;
            end

            mDone = (mDone && !clearDone) || done_i;
            mLive = 1;
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge aclk) begin
        if (compareOn) begin
            logic [32*NUM_CFG-1:0] expCfg;
            for (int i = 0; i < NUM_CFG; i++) expCfg[32*i +: 32] = mCfg[i];
            checkOutput("awready", s_axi_awready, mLive && !mAwPend && !mB);
            checkOutput("wready",  s_axi_wready,  mLive && !mWPend  && !mB);
            checkOutput("arready", s_axi_arready, mLive && !mArPend && !mR);
            checkOutput("bvalid",  s_axi_bvalid,  mB);
            checkOutput("rvalid",  s_axi_rvalid,  mR);
            if (mB) checkOutput("bresp", s_axi_bresp, mBresp);
            if (mR) begin
                checkOutput("rdata", s_axi_rdata, mRdata);
                checkOutput("rresp", s_axi_rresp, mRresp);
            end
            checkOutput("start_o", start_o, mStart);
            checkOutput("irq_o",   irq_o,   mIrqEn && mDone);
            checkOutput("cfg_o",   cfg_o,   expCfg);
        end
    end

    always @(negedge aclk) if (start_o) startCount++;

    // ---------------- bus tasks ----------------
    task automatic axiWrite(input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int wLead, input int bHold,
                            input bit pulseDoneAtCommit, output logic [1:0] resp);
        int cyc;
        bit awDone, wDone, awHs, wHs, seen;
        cyc = 0; awDone = 0; wDone = 0; resp = 2'b11;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_wvalid = 1; s_axi_bready = 0;
        while (!(awDone && wDone) && cyc < 40) begin
            if (cyc >= wLead && !awDone) s_axi_awvalid = 1;
            @(negedge aclk);
            awHs = s_axi_awvalid && s_axi_awready;
            wHs  = s_axi_wvalid && s_axi_wready;
            @(posedge aclk); #1;
            if (awHs) begin s_axi_awvalid = 0; awDone = 1; end
            if (wHs)  begin s_axi_wvalid  = 0; wDone  = 1; end
            cyc++;
        end
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        checkOutput("aw_w_handshake", {awDone, wDone}, 2'b11);
        if (pulseDoneAtCommit) begin
            done_i = 1; @(posedge aclk); #1; done_i = 0;
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge aclk); seen = s_axi_bvalid;
        end
        checkOutput("bvalid_seen", seen, 1'b1);
        resp = s_axi_bresp;
        repeat (bHold) begin
            @(posedge aclk); #1;
            checkOutput("bvalid_hold", s_axi_bvalid, 1'b1);
            checkOutput("awready_hold", s_axi_awready, 1'b0);
            checkOutput("wready_hold", s_axi_wready, 1'b0);
        end
        s_axi_bready = 1;
        @(posedge aclk); #1;
        s_axi_bready = 0;
    endtask

    task automatic axiRead(input logic [11:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        bit hs, seen;
        hs = 0; seen = 0; data = '0; resp = 2'b11;
        s_axi_araddr = addr; s_axi_arvalid = 1; s_axi_rready = 0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge aclk); hs = s_axi_arready;
            @(posedge aclk); #1;
        end
        s_axi_arvalid = 0;
        checkOutput("ar_handshake", hs, 1'b1);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge aclk); seen = s_axi_rvalid;
        end
        checkOutput("rvalid_seen", seen, 1'b1);
        data = s_axi_rdata; resp = s_axi_rresp;
        s_axi_rready = 1;
        @(posedge aclk); #1;
        s_axi_rready = 0;
    endtask

    // ---------------- directed sequence ----------------
    task automatic applyStimulus();
        logic [1:0]  resp;
        logic [31:0] rd;
        int          startBefore;
        bit          hs;

        // Reset state and ready rise after release
        #2 aresetn = 0;
        compareOn = 1;
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_awready", s_axi_awready, 1'b0);
        checkOutput("rst_bvalid", s_axi_bvalid, 1'b0);
        checkOutput("rst_rdata", s_axi_rdata, 32'h0);
        checkOutput("rst_cfg", cfg_o, '0);
        aresetn = 1;
        #1 checkOutput("rel_awready_low", s_axi_awready, 1'b0);
        @(posedge aclk); #1;
        checkOutput("rel_awready_high", s_axi_awready, 1'b1);
        checkOutput("rel_arready_high", s_axi_arready, 1'b1);

        // 1: simple CFG write/read
        axiWrite(12'h008, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp);
        checkOutput("t1_bresp", resp, 2'b00);
        checkOutput("t1_cfg", cfg_o[31:0], 32'hDEADBEEF);
        axiRead(12'h008, rd, resp);
        checkOutput("t1_rdata", rd, 32'hDEADBEEF);
        checkOutput("t1_rresp", resp, 2'b00);
        axiRead(12'h00A, rd, resp);
        checkOutput("t1_rdata_lowbits", rd, 32'hDEADBEEF);

        // 2: W leads AW by 3 cycles, B stalled 5 cycles
        axiWrite(12'h010, 32'h12345678, 4'hF, 3, 5, 0, resp);
        checkOutput("t2_bresp", resp, 2'b00);
        checkOutput("t2_cfg", cfg_o[95:64], 32'h12345678);
        axiRead(12'h010, rd, resp);
        checkOutput("t2_rdata", rd, 32'h12345678);

        // 3: out-of-range access
        axiWrite(12'h100, 32'h1, 4'hF, 0, 0, 0, resp);
        checkOutput("t3_bresp", resp, 2'b10);
        axiRead(12'h100, rd, resp);
        checkOutput("t3_rdata", rd, 32'h0);
        checkOutput("t3_rresp", resp, 2'b10);
        axiRead(12'h000, rd, resp);
        checkOutput("t3_ctrl_untouched", rd, 32'h0);

        // 4: start pulse, done/irq, W1C and set-wins
        startBefore = startCount;
        axiWrite(12'h000, 32'h3, 4'hF, 0, 0, 0, resp);
        checkOutput("t4_start_pulses", startCount - startBefore, 1);
        axiRead(12'h000, rd, resp);
        checkOutput("t4_ctrl_read", rd, 32'h2);
        checkOutput("t4_irq_idle", irq_o, 1'b0);
        done_i = 1; @(posedge aclk); #1; done_i = 0;
        checkOutput("t4_irq_set", irq_o, 1'b1);
        axiRead(12'h004, rd, resp);
        checkOutput("t4_status", rd, 32'h2);
        axiWrite(12'h004, 32'h2, 4'hF, 0, 0, 0, resp);
        checkOutput("t4_irq_cleared", irq_o, 1'b0);
        axiWrite(12'h004, 32'h2, 4'hF, 0, 0, 1, resp);
        checkOutput("t4_irq_setwins", irq_o, 1'b1);
        busy_i = 1;
        axiRead(12'h004, rd, resp);
        checkOutput("t4_status_busy", rd, 32'h3);
        busy_i = 0;

        // 5: byte strobes
        axiWrite(12'h00C, 32'h11223344, 4'hF, 0, 0, 0, resp);
        axiWrite(12'h00C, 32'hAABBCCDD, 4'b0101, 0, 0, 0, resp);
        axiRead(12'h00C, rd, resp);
`ifdef CNN_AXIL_WSTRB_EN
        checkOutput("t5_strb", rd, 32'h11BB33DD);
        axiWrite(12'h00C, 32'h0, 4'h0, 0, 0, 0, resp);
        checkOutput("t5_nostrb_bresp", resp, 2'b00);
        checkOutput("t5_nostrb_cfg", cfg_o[63:32], 32'h11BB33DD);
`else
        checkOutput("t5_strb", rd, 32'hAABBCCDD);
        axiWrite(12'h00C, 32'h0, 4'h0, 0, 0, 0, resp);
        checkOutput("t5_nostrb_bresp", resp, 2'b00);
        checkOutput("t5_nostrb_cfg", cfg_o[63:32], 32'h0);
`endif

        // 6: reset mid-transaction with bvalid pending and AR held
        s_axi_awaddr = 12'h008; s_axi_wdata = 32'h55AA55AA; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_bready = 0;
        @(posedge aclk); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        @(posedge aclk); #1;
        checkOutput("t6_bvalid_pending", s_axi_bvalid, 1'b1);
        s_axi_araddr = 12'h008; s_axi_arvalid = 1;
        @(negedge aclk); hs = s_axi_arready;
        checkOutput("t6_ar_hs", hs, 1'b1);
        @(posedge aclk); #1;
        s_axi_arvalid = 0;
        checkOutput("t6_irq_before", irq_o, 1'b1);
        aresetn = 0;
        #1;
        checkOutput("t6_bvalid", s_axi_bvalid, 1'b0);
        checkOutput("t6_rvalid", s_axi_rvalid, 1'b0);
        checkOutput("t6_arready", s_axi_arready, 1'b0);
        checkOutput("t6_irq", irq_o, 1'b0);
        checkOutput("t6_cfg", cfg_o, '0);
        @(posedge aclk); #1;
        aresetn = 1;
        @(posedge aclk); #1;
        checkOutput("t6_awready_back", s_axi_awready, 1'b1);
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("t6_no_stale_r", s_axi_rvalid, 1'b0);
        checkOutput("t6_no_stale_b", s_axi_bvalid, 1'b0);
        axiRead(12'h008, rd, resp);
        checkOutput("t6_reg_cleared", rd, 32'h0);
    endtask

    initial begin
        applyStimulus();
        repeat (2) @(posedge aclk);
        compareOn = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
